// File: rtl/sm4_pkg.sv
// Shared SM4 CK definitions: round count, byte step, sequencer state type and
// the arithmetic CK generator used in place of a 32-entry table.
package sm4_pkg;

  localparam int SM4_ROUNDS  = 32;
  localparam int SM4_CK_STEP = 7;
  // Consecutive CK words advance each byte by 4*7 = 28.
  localparam int SM4_CK_MUL  = 4 * SM4_CK_STEP;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_t;

  // Byte j (0 = MSB) of CK[i] is (28*i + 7*j) mod 256; 8-bit carries wrap.
  function automatic logic [31:0] sm4_ck(input logic [4:0] i);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    b = 8'({3'b000, i} * 8'(SM4_CK_MUL));
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = b;
      b = b + 8'(SM4_CK_STEP);
    end
    return w;
  endfunction

endpackage

// File: rtl/sm4_ck_seq_if.sv
// Bundle between the key-expansion controller (master) and the CK sequencer
// (slave): schedule control, streamed CK beats and the random-access lookup.
interface sm4_ck_seq_if #(
  parameter int LANES = 1
);
  logic                  start;
  logic                  dir;
  logic                  ready;
  logic                  valid;
  logic [32*LANES-1:0]   cki_out;
  logic [4:0]            cki_idx;
  logic                  busy;
  logic                  done;
  logic [4:0]            lut_idx;
  logic [31:0]           lut_ck;

  modport master (
    output start, dir, ready, lut_idx,
    input  valid, cki_out, cki_idx, busy, done, lut_ck
  );

  modport slave (
    input  start, dir, ready, lut_idx,
    output valid, cki_out, cki_idx, busy, done, lut_ck
  );
endinterface

// File: rtl/sm4_ck_word.sv
// Combinational CK word generator: index in, 32-bit round constant out.
module sm4_ck_word
  import sm4_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [31:0] ck
);
  assign ck = sm4_ck(idx);
endmodule

// File: rtl/sm4_ck_seq.sv
// SM4 CK sequencer: streams the 32 round constants LANES per beat, forward or
// reverse, with valid/ready flow control, plus a registered lookup port.
module sm4_ck_seq
  import sm4_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int ROUNDS = SM4_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  sm4_ck_seq_if.slave   bus
);
  localparam int         BEATS     = ROUNDS / LANES;
  localparam logic [4:0] STEP      = 5'(LANES);
  localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

  seq_state_t          state_reg;
  logic                dir_reg;
  logic [4:0]          base_reg;
  logic [4:0]          beat_reg;
  logic                valid_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [32*LANES-1:0] cki_out_reg;
  logic [4:0]          cki_idx_reg;
  logic [31:0]         lut_ck_reg;

  logic                dir_next;
  logic [4:0]          base_next;
  logic [4:0]          lane_idx [LANES];
  logic [32*LANES-1:0] lane_ck;
  logic [31:0]         lut_word;

  // Base of the beat that would be registered at the next edge: the first
  // beat when idle, the following beat while running.
  always_comb begin
    dir_next  = dir_reg;
    base_next = dir_reg ? base_reg - STEP : base_reg + STEP;
    if (state_reg == ST_IDLE) begin
      dir_next  = bus.dir;
      base_next = bus.dir ? 5'd31 : 5'd0;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_idx[gi] = dir_next ? base_next - 5'(gi) : base_next + 5'(gi);
      sm4_ck_word u_word (
        .idx (lane_idx[gi]),
        .ck  (lane_ck[32*gi +: 32])
      );
    end
  endgenerate

  sm4_ck_word u_lut_word (
    .idx (bus.lut_idx),
    .ck  (lut_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      dir_reg     <= 1'b0;
      base_reg    <= '0;
      beat_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cki_out_reg <= '0;
      cki_idx_reg <= '0;
      lut_ck_reg  <= '0;
    end else begin
      lut_ck_reg <= lut_word;
      done_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            dir_reg     <= dir_next;
            base_reg    <= base_next;
            beat_reg    <= '0;
            cki_out_reg <= lane_ck;
            cki_idx_reg <= base_next;
            valid_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (valid_reg && bus.ready) begin
            if (beat_reg == LAST_BEAT) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              // Next beat loads on the accepting edge, so there is no bubble.
              beat_reg    <= beat_reg + 5'd1;
              base_reg    <= base_next;
              cki_out_reg <= lane_ck;
              cki_idx_reg <= base_next;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.valid   = valid_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.cki_out = cki_out_reg;
  assign bus.cki_idx = cki_idx_reg;
  assign bus.lut_ck  = lut_ck_reg;

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Directed bench for sm4_ck_seq with one LANES=1 and one LANES=4 instance
// sharing clock and reset.
module tb_sm4_ck_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm4_ck_seq_if #(.LANES(1)) s1 ();
  sm4_ck_seq_if #(.LANES(4)) s4 ();

  sm4_ck_seq #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(s1));
  sm4_ck_seq #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(s4));

  int n_checks = 0;
  int n_err    = 0;

  // Independent reference: byte j of CK[i] = (28*i + 7*j) mod 256.
  function automatic logic [31:0] tb_ck(input int i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[8*(3-j) +: 8] = 8'((28*i + 7*j) % 256);
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Caller raises start (and dir) before calling; returns in the done cycle.
  task automatic run1(input logic d, input int stall_at, input int stall_n, input bit poke);
    int beats = 0;
    int cyc = 0;
    int left = stall_n;
    int exp_idx;
    int prev_lut = -1;
    @(posedge clk); #1;
    s1.start = 1'b0;
    check("L1 valid at T+1", s1.valid, 1);
    check("L1 busy at T+1", s1.busy, 1);
    while (beats < 32 && cyc < 100) begin
      exp_idx = d ? 31 - beats : beats;
      check($sformatf("L1 cki_out[%0d]", exp_idx), s1.cki_out, tb_ck(exp_idx));
      check($sformatf("L1 cki_idx[%0d]", exp_idx), s1.cki_idx, exp_idx);
      check("L1 valid", s1.valid, 1);
      if (exp_idx == 0)  check("L1 CK0 literal", s1.cki_out, 32'h00070e15);
      if (exp_idx == 31) check("L1 CK31 literal", s1.cki_out, 32'h646b7279);
      if (!d && beats == 2 && left < stall_n) check("L1 hold beat2", s1.cki_out, 32'h383f464d);
      if (prev_lut >= 0) check($sformatf("lut_ck[%0d]", prev_lut), s1.lut_ck, tb_ck(prev_lut));
      prev_lut = cyc % 32;
      s1.lut_idx = 5'(prev_lut);
      s1.start = poke && beats == 5;
      s1.dir   = (poke && beats == 5) ? ~d : d;
      if (beats == stall_at && left > 0) begin
        s1.ready = 1'b0;
        left--;
      end else begin
        s1.ready = 1'b1;
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) check("L1 schedule timeout", 0, 1);
    s1.start = 1'b0;
    s1.dir   = d;
    check("L1 done pulse", s1.done, 1);
    check("L1 valid after last", s1.valid, 0);
    check("L1 busy after last", s1.busy, 0);
  endtask

  task automatic run4(input logic d);
    int base;
    s4.start = 1'b1;
    s4.dir   = d;
    s4.ready = 1'b1;
    @(posedge clk); #1;
    s4.start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      base = d ? 31 - 4*b : 4*b;
      check("L4 valid", s4.valid, 1);
      check($sformatf("L4 cki_idx b%0d", b), s4.cki_idx, base);
      for (int k = 0; k < 4; k++)
        check($sformatf("L4 b%0d lane%0d", b, k), s4.cki_out[32*k +: 32],
              tb_ck(d ? base - k : base + k));
      if (b == 0 && !d)
        check("L4 fwd first beat", s4.cki_out,
              {32'h545b6269, 32'h383f464d, 32'h1c232a31, 32'h00070e15});
      if (b == 0 && d) begin
        check("L4 rev lane0", s4.cki_out[31:0], 32'h646b7279);
        check("L4 rev lane3", s4.cki_out[127:96], 32'h10171e25);
      end
      @(posedge clk); #1;
    end
    check("L4 done pulse", s4.done, 1);
    check("L4 valid after last", s4.valid, 0);
    @(posedge clk); #1;
    check("L4 done cleared", s4.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    s1.start = 0; s1.dir = 0; s1.ready = 0; s1.lut_idx = 0;
    s4.start = 0; s4.dir = 0; s4.ready = 0; s4.lut_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", s1.valid, 0);
    check("reset busy", s1.busy, 0);
    check("reset done", s1.done, 0);
    check("reset cki_out", s1.cki_out, 0);
    check("reset cki_idx", s1.cki_idx, 0);
    check("reset lut_ck", s1.lut_ck, 0);
    check("reset L4 cki_out", s4.cki_out, 0);
    rst = 1'b0;

    s1.lut_idx = 5'd9;
    @(posedge clk); #1;
    check("lut idx9", s1.lut_ck, 32'hfc030a11);

    // Forward, then reverse followed back-to-back by a stalled/poked forward run.
    s1.start = 1; s1.dir = 0; s1.ready = 1;
    run1(1'b0, -1, 0, 1'b0);
    @(posedge clk); #1;
    check("L1 done one cycle", s1.done, 0);
    s1.start = 1; s1.dir = 1;
    run1(1'b1, -1, 0, 1'b0);
    s1.start = 1; s1.dir = 0;
    run1(1'b0, 2, 3, 1'b1);
    @(posedge clk); #1;
    check("L1 idle after b2b", s1.busy, 0);

    // Asynchronous reset at beat 10.
    s1.lut_idx = 5'd9;
    s1.start = 1; s1.dir = 0; s1.ready = 1;
    @(posedge clk); #1;
    s1.start = 0;
    repeat (10) @(posedge clk);
    #1;
    check("L1 beat10 idx", s1.cki_idx, 10);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", s1.valid, 0);
    check("async rst busy", s1.busy, 0);
    check("async rst cki_out", s1.cki_out, 0);
    check("async rst cki_idx", s1.cki_idx, 0);
    check("async rst lut_ck", s1.lut_ck, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s1.valid || s1.done) saw = 1'b1;
    end
    check("no beat or done after rst", saw, 0);

    run4(1'b0);
    run4(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
